matmul_scratchpad_bank: RTL and testbench

Multi-slot result store for the matrix-multiply datapath. On each done pulse it captures a full MAX_DIM x MAX_DIM result matrix, plus per-element overflow flags, into one of NUM_SLOTS slots. Stored results are read back two ways: a 1-cycle random-access read port, and a valid/ready streaming drain of a whole slot in row-major order. It sits between the systolic array outputs and the bus/readout logic.

---
 rtl/matmul_sp_pkg.sv | 17 +
 rtl/matmul_sp_drain_fsm.sv | 77 +++++++
 rtl/matmul_scratchpad_bank.sv | 140 ++++++++++++++
 tb/tb_matmul_scratchpad_bank.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_sp_pkg.sv
// Shared sizes and drain FSM state type for the matmul scratchpad bank.
package matmul_sp_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MAX_DIM    = 4;
  localparam int DEF_NUM_SLOTS  = 4;

  localparam int MATRIX_SIZE = DEF_MAX_DIM * DEF_MAX_DIM;
  localparam int SLOT_W      = $clog2(DEF_NUM_SLOTS);
  localparam int IDX_W       = $clog2(MATRIX_SIZE);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_e;

endpackage

// File: rtl/matmul_sp_drain_fsm.sv
// Streaming drain sequencer: latches the slot, walks the element index, flags the last beat.
//   state  | meaning
//   IDLE   | no drain active, waiting for drain_start_i
//   STREAM | presenting element idx_q of slot_q, advancing on valid && ready
module matmul_sp_drain_fsm
  import matmul_sp_pkg::*;
#(
  parameter int N_ELEM    = MATRIX_SIZE,
  parameter int SLOT_BITS = SLOT_W,
  parameter int IDX_BITS  = IDX_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 drain_start_i,
  input  logic [SLOT_BITS-1:0] drain_slot_i,
  input  logic                 drn_ready_i,
  output logic [SLOT_BITS-1:0] slot_o,
  output logic [IDX_BITS-1:0]  idx_o,
  output logic                 valid_o,
  output logic                 last_o,
  output logic                 busy_o
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N_ELEM - 1);

  drain_state_e         state_q, state_d;
  logic [SLOT_BITS-1:0] slot_q, slot_d;
  logic [IDX_BITS-1:0]  idx_q, idx_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      slot_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    idx_d   = idx_q;
    valid_o = 1'b0;
    last_o  = 1'b0;
    busy_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (drain_start_i) begin
          slot_d  = drain_slot_i;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        busy_o  = 1'b1;
        valid_o = 1'b1;
        last_o  = (idx_q == LAST_IDX);
        if (drn_ready_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign slot_o = slot_q;
  assign idx_o  = idx_q;

endmodule

// File: rtl/matmul_scratchpad_bank.sv
// Multi-slot result store: whole-matrix capture, 1-cycle random read, valid/ready drain.
// Optional accumulate-on-capture is enabled by defining SCRATCHPAD_ACCUM_EN (adds acc_i).
module matmul_scratchpad_bank
  import matmul_sp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_DIM    = DEF_MAX_DIM,
  parameter int NUM_SLOTS  = DEF_NUM_SLOTS
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    done_i,
`ifdef SCRATCHPAD_ACCUM_EN
  input  logic                                    acc_i,
`endif
  input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]   res_flat_i,
  input  logic [MAX_DIM*MAX_DIM-1:0]              ovf_flat_i,
  input  logic [$clog2(NUM_SLOTS)-1:0]            wr_slot_i,
  input  logic                                    rd_en_i,
  input  logic [$clog2(NUM_SLOTS)-1:0]            rd_slot_i,
  input  logic [$clog2(MAX_DIM*MAX_DIM)-1:0]      rd_idx_i,
  output logic [DATA_WIDTH-1:0]                   rd_data_o,
  output logic                                    rd_ovf_o,
  output logic                                    rd_valid_o,
  input  logic                                    drain_start_i,
  input  logic [$clog2(NUM_SLOTS)-1:0]            drain_slot_i,
  output logic [DATA_WIDTH-1:0]                   drn_data_o,
  output logic                                    drn_ovf_o,
  output logic                                    drn_last_o,
  output logic                                    drn_valid_o,
  input  logic                                    drn_ready_i,
  output logic                                    busy_o,
  output logic [NUM_SLOTS-1:0]                    slot_valid_o,
  input  logic [NUM_SLOTS-1:0]                    slot_clr_i
);

  localparam int N_ELEM    = MAX_DIM * MAX_DIM;
  localparam int SLOT_BITS = $clog2(NUM_SLOTS);
  localparam int IDX_BITS  = $clog2(N_ELEM);

  logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS][N_ELEM];
  logic [N_ELEM-1:0]     ovf_q [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] cap_data [N_ELEM];
  logic [N_ELEM-1:0]     cap_ovf;
`ifdef SCRATCHPAD_ACCUM_EN
  logic [DATA_WIDTH:0]   acc_sum [N_ELEM];
`endif

  logic [NUM_SLOTS-1:0]  slot_valid_q, slot_valid_d, slot_set;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_ovf_q, rd_valid_q;

  logic [SLOT_BITS-1:0]  drn_slot;
  logic [IDX_BITS-1:0]   drn_idx;
  logic                  drn_valid;

  // Capture value per element; accumulate mode folds in the carry-out as overflow.
  always_comb begin
    cap_ovf = ovf_flat_i;
    for (int k = 0; k < N_ELEM; k++) begin
      cap_data[k] = res_flat_i[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef SCRATCHPAD_ACCUM_EN
      acc_sum[k] = {1'b0, mem_q[wr_slot_i][k]} + {1'b0, res_flat_i[k*DATA_WIDTH +: DATA_WIDTH]};
      if (acc_i) begin
        cap_data[k] = acc_sum[k][DATA_WIDTH-1:0];
        cap_ovf[k]  = ovf_q[wr_slot_i][k] | ovf_flat_i[k] | acc_sum[k][DATA_WIDTH];
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        ovf_q[s] <= '0;
        for (int k = 0; k < N_ELEM; k++) begin
          mem_q[s][k] <= '0;
        end
      end
    end else if (done_i) begin
      ovf_q[wr_slot_i] <= cap_ovf;
      for (int k = 0; k < N_ELEM; k++) begin
        mem_q[wr_slot_i][k] <= cap_data[k];
      end
    end
  end

  // A capture in the same cycle as a clear of that slot leaves it valid.
  always_comb begin
    slot_set = '0;
    if (done_i) begin
      slot_set[wr_slot_i] = 1'b1;
    end
    slot_valid_d = (slot_valid_q & ~slot_clr_i) | slot_set;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_valid_q <= '0;
      rd_data_q    <= '0;
      rd_ovf_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      rd_valid_q   <= rd_en_i;
      if (rd_en_i) begin
        rd_data_q <= mem_q[rd_slot_i][rd_idx_i];
        rd_ovf_q  <= ovf_q[rd_slot_i][rd_idx_i];
      end
    end
  end

  matmul_sp_drain_fsm #(
    .N_ELEM    (N_ELEM),
    .SLOT_BITS (SLOT_BITS),
    .IDX_BITS  (IDX_BITS)
  ) u_drain_fsm (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .drain_start_i (drain_start_i),
    .drain_slot_i  (drain_slot_i),
    .drn_ready_i   (drn_ready_i),
    .slot_o        (drn_slot),
    .idx_o         (drn_idx),
    .valid_o       (drn_valid),
    .last_o        (drn_last_o),
    .busy_o        (busy_o)
  );

  // Drain reads storage live, so a capture into the current element shows up next cycle.
  assign drn_valid_o  = drn_valid;
  assign drn_data_o   = drn_valid ? mem_q[drn_slot][drn_idx] : '0;
  assign drn_ovf_o    = drn_valid & ovf_q[drn_slot][drn_idx];

  assign rd_data_o    = rd_data_q;
  assign rd_ovf_o     = rd_ovf_q;
  assign rd_valid_o   = rd_valid_q;
  assign slot_valid_o = slot_valid_q;

endmodule

// File: tb/tb_matmul_scratchpad_bank.sv
// Scoreboard bench for matmul_scratchpad_bank: queued drain expectations plus direct read checks.
module tb_matmul_scratchpad_bank;

  localparam int DW = 32;
  localparam int NS = 4;
  localparam int MS = 16;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            done_i;
`ifdef SCRATCHPAD_ACCUM_EN
  logic            acc_i;
`endif
  logic [MS*DW-1:0] res_flat_i;
  logic [MS-1:0]   ovf_flat_i;
  logic [1:0]      wr_slot_i;
  logic            rd_en_i;
  logic [1:0]      rd_slot_i;
  logic [3:0]      rd_idx_i;
  logic [DW-1:0]   rd_data_o;
  logic            rd_ovf_o;
  logic            rd_valid_o;
  logic            drain_start_i;
  logic [1:0]      drain_slot_i;
  logic [DW-1:0]   drn_data_o;
  logic            drn_ovf_o;
  logic            drn_last_o;
  logic            drn_valid_o;
  logic            drn_ready_i;
  logic            busy_o;
  logic [NS-1:0]   slot_valid_o;
  logic [NS-1:0]   slot_clr_i;

  always #5 clk_i = ~clk_i;

  matmul_scratchpad_bank dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .done_i        (done_i),
`ifdef SCRATCHPAD_ACCUM_EN
    .acc_i         (acc_i),
`endif
    .res_flat_i    (res_flat_i),
    .ovf_flat_i    (ovf_flat_i),
    .wr_slot_i     (wr_slot_i),
    .rd_en_i       (rd_en_i),
    .rd_slot_i     (rd_slot_i),
    .rd_idx_i      (rd_idx_i),
    .rd_data_o     (rd_data_o),
    .rd_ovf_o      (rd_ovf_o),
    .rd_valid_o    (rd_valid_o),
    .drain_start_i (drain_start_i),
    .drain_slot_i  (drain_slot_i),
    .drn_data_o    (drn_data_o),
    .drn_ovf_o     (drn_ovf_o),
    .drn_last_o    (drn_last_o),
    .drn_valid_o   (drn_valid_o),
    .drn_ready_i   (drn_ready_i),
    .busy_o        (busy_o),
    .slot_valid_o  (slot_valid_o),
    .slot_clr_i    (slot_clr_i)
  );

  int errors = 0;
  int checks = 0;
  int beats  = 0;

  logic [DW+1:0] exp_q [$];
  logic [DW-1:0] model_mem [NS][MS];
  logic          model_ovf [NS][MS];

  logic          stall_prev = 1'b0;
  logic          cap_prev   = 1'b0;
  logic [DW+1:0] stall_val;
  logic [DW+1:0] obs, exp_beat;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drives a capture of element k = base + k into slot; caller deasserts done_i.
  task automatic set_capture(input logic [1:0] slot, input int base, input logic [MS-1:0] ovf);
    for (int k = 0; k < MS; k++) begin
      res_flat_i[k*DW +: DW] = DW'(base + k);
      model_mem[slot][k]     = DW'(base + k);
      model_ovf[slot][k]     = ovf[k];
    end
    ovf_flat_i = ovf;
    wr_slot_i  = slot;
    done_i     = 1'b1;
  endtask

  task automatic push_drain(input logic [1:0] slot, input int count);
    for (int k = 0; k < count; k++) begin
      exp_q.push_back({(k == MS - 1), model_ovf[slot][k], model_mem[slot][k]});
    end
  endtask

  // Starts a drain and steps ready from a 4-cycle pattern until busy drops.
  task automatic run_drain(input logic [1:0] slot, input logic [3:0] pat, output int cycles);
    cycles = 0;
    @(posedge clk_i); #1;
    drain_start_i = 1'b1;
    drain_slot_i  = slot;
    @(posedge clk_i); #1;
    drain_start_i = 1'b0;
    while (busy_o && cycles < 200) begin
      drn_ready_i   = pat[cycles % 4];
      drain_start_i = (cycles == 4);
      drain_slot_i  = slot ^ 2'd1;
      @(posedge clk_i); #1;
      cycles++;
    end
    drn_ready_i   = 1'b0;
    drain_start_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    obs = {drn_last_o, drn_ovf_o, drn_data_o};
    if (drn_valid_o && drn_ready_i) begin
      beats++;
      check_val("drn_beat_expected", {63'b0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        exp_beat = exp_q.pop_front();
        check_val($sformatf("drn_beat_%0d", beats), obs, exp_beat);
      end
      stall_prev = 1'b0;
    end else if (drn_valid_o && !drn_ready_i) begin
      if (stall_prev && !cap_prev) begin
        check_val("drn_stall_stable", obs, stall_val);
      end
      stall_prev = 1'b1;
      stall_val  = obs;
    end else begin
      stall_prev = 1'b0;
    end
    cap_prev = done_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int beats0;
    rst_i = 1'b1; done_i = 1'b0; res_flat_i = '0; ovf_flat_i = '0; wr_slot_i = '0;
    rd_en_i = 1'b0; rd_slot_i = '0; rd_idx_i = '0; drain_start_i = 1'b0;
    drain_slot_i = '0; drn_ready_i = 1'b0; slot_clr_i = '0;
`ifdef SCRATCHPAD_ACCUM_EN
    acc_i = 1'b0;
`endif
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < MS; k++) begin
        model_mem[s][k] = '0;
        model_ovf[s][k] = 1'b0;
      end
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_val("rst_slot_valid", slot_valid_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_rd_valid", rd_valid_o, 0);
    check_val("rst_drn_valid", drn_valid_o, 0);

    // Capture k+1 into slot 2, then random read of idx 5
    @(posedge clk_i); #1;
    set_capture(2'd2, 1, 16'h0020);
    @(posedge clk_i); #1;
    done_i = 1'b0; rd_en_i = 1'b1; rd_slot_i = 2'd2; rd_idx_i = 4'd5;
    @(negedge clk_i);
    check_val("t1_slot_valid", slot_valid_o, 4'b0100);
    check_val("t1_rd_valid_early", rd_valid_o, 0);
    @(posedge clk_i); #1;
    rd_en_i = 1'b0;
    @(negedge clk_i);
    check_val("t1_rd_data", rd_data_o, 6);
    check_val("t1_rd_ovf", rd_ovf_o, 1);
    check_val("t1_rd_valid", rd_valid_o, 1);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_val("t1_rd_valid_drop", rd_valid_o, 0);
    check_val("t1_rd_data_hold", rd_data_o, 6);

    // Full-rate drain of slot 2
    beats0 = beats;
    push_drain(2'd2, MS);
    run_drain(2'd2, 4'b1111, cyc);
    check_val("t2_cycles", cyc, 16);
    check_val("t2_beats", beats - beats0, 16);
    check_val("t2_queue_empty", exp_q.size(), 0);
    @(negedge clk_i);
    check_val("t2_busy_after", busy_o, 0);
    check_val("t2_valid_after", drn_valid_o, 0);

    // Drain with ready pattern 1,0,0,1
    beats0 = beats;
    push_drain(2'd2, MS);
    run_drain(2'd2, 4'b1001, cyc);
    check_val("t3_cycles", cyc, 32);
    check_val("t3_beats", beats - beats0, 16);
    check_val("t3_queue_empty", exp_q.size(), 0);

    // Live rewrite of slot 2 while the drain is stalled at k=3
    beats0 = beats;
    for (int k = 0; k < MS; k++) begin
      if (k < 3) exp_q.push_back({1'b0, model_ovf[2][k], model_mem[2][k]});
      else       exp_q.push_back({(k == MS - 1), 1'b0, DW'(100 + k)});
    end
    @(posedge clk_i); #1;
    drain_start_i = 1'b1; drain_slot_i = 2'd2;
    @(posedge clk_i); #1;
    drain_start_i = 1'b0; drn_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    drn_ready_i = 1'b0;
    set_capture(2'd2, 100, 16'h0000);
    rd_en_i = 1'b1; rd_slot_i = 2'd2; rd_idx_i = 4'd3;
    @(posedge clk_i); #1;
    done_i = 1'b0; rd_en_i = 1'b0;
    @(negedge clk_i);
    check_val("t4_rd_old_content", rd_data_o, 4);
    check_val("t4_drn_live_value", drn_data_o, 103);
    check_val("t4_drn_still_valid", drn_valid_o, 1);
    @(posedge clk_i); #1;
    drn_ready_i = 1'b1;
    cyc = 0;
    while (busy_o && cyc < 100) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    drn_ready_i = 1'b0;
    check_val("t4_beats", beats - beats0, 16);
    check_val("t4_queue_empty", exp_q.size(), 0);

    // Same-cycle capture and clear of slot 1; clear slot 2 keeps its data
    @(posedge clk_i); #1;
    set_capture(2'd1, 200, 16'h8001);
    slot_clr_i = 4'b0110;
    @(posedge clk_i); #1;
    done_i = 1'b0; slot_clr_i = '0;
    rd_en_i = 1'b1; rd_slot_i = 2'd2; rd_idx_i = 4'd0;
    @(negedge clk_i);
    check_val("t5_slot_valid", slot_valid_o, 4'b0010);
    @(posedge clk_i); #1;
    rd_en_i = 1'b0;
    @(negedge clk_i);
    check_val("t5_cleared_data_kept", rd_data_o, model_mem[2][0]);

    // Reset while drain of slot 1 presents beat k=7
    beats0 = beats;
    push_drain(2'd1, 7);
    @(posedge clk_i); #1;
    drain_start_i = 1'b1; drain_slot_i = 2'd1;
    @(posedge clk_i); #1;
    drain_start_i = 1'b0; drn_ready_i = 1'b1;
    repeat (7) @(posedge clk_i);
    #1;
    drn_ready_i = 1'b0; rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_val("t5_rst_beats", beats - beats0, 7);
    check_val("t5_rst_queue_empty", exp_q.size(), 0);
    check_val("t5_rst_drn_valid", drn_valid_o, 0);
    check_val("t5_rst_drn_data", drn_data_o, 0);
    check_val("t5_rst_drn_last", drn_last_o, 0);
    check_val("t5_rst_drn_ovf", drn_ovf_o, 0);
    check_val("t5_rst_busy", busy_o, 0);
    check_val("t5_rst_slot_valid", slot_valid_o, 0);
    check_val("t5_rst_rd_data", rd_data_o, 0);
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < MS; k++) begin
        model_mem[s][k] = '0;
        model_ovf[s][k] = 1'b0;
      end
    @(posedge clk_i); #1;
    rd_en_i = 1'b1; rd_slot_i = 2'd1; rd_idx_i = 4'd0;
    @(posedge clk_i); #1;
    rd_en_i = 1'b0;
    @(negedge clk_i);
    check_val("t5_rst_storage", rd_data_o, model_mem[1][0]);
    check_val("t5_rst_busy_idle", busy_o, 0);

`ifdef SCRATCHPAD_ACCUM_EN
    // Accumulate with wrap: 0xFFFFFFFF + 2 = 1 with carry-out overflow
    @(posedge clk_i); #1;
    set_capture(2'd0, 0, 16'h0000);
    res_flat_i[0 +: DW]  = 32'hFFFF_FFFF;
    res_flat_i[DW +: DW] = 32'd5;
    acc_i = 1'b0;
    @(posedge clk_i); #1;
    set_capture(2'd0, 0, 16'h0000);
    res_flat_i[0 +: DW]  = 32'd2;
    res_flat_i[DW +: DW] = 32'd7;
    acc_i = 1'b1;
    @(posedge clk_i); #1;
    done_i = 1'b0; acc_i = 1'b0;
    rd_en_i = 1'b1; rd_slot_i = 2'd0; rd_idx_i = 4'd0;
    @(posedge clk_i); #1;
    rd_idx_i = 4'd1;
    @(negedge clk_i);
    check_val("t6_acc_wrap_data", rd_data_o, 1);
    check_val("t6_acc_wrap_ovf", rd_ovf_o, 1);
    @(posedge clk_i); #1;
    rd_en_i = 1'b0;
    @(negedge clk_i);
    check_val("t6_acc_plain_data", rd_data_o, 12);
    check_val("t6_acc_plain_ovf", rd_ovf_o, 0);
`endif

    repeat (2) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
